// File: rtl/spart_rx_if.sv
// SPART receiver host bus: chip select, direction and address from the host,
// receive buffer and data-available status back to the host.
interface spart_rx_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] rx_data;
   logic       rda;

   modport master (
      output iocs,
      output iorw,
      output ioaddr,
      input  rx_data,
      input  rda
   );

   modport slave (
      input  iocs,
      input  iorw,
      input  ioaddr,
      output rx_data,
      output rda
   );
endinterface

// File: rtl/spart_rx.sv
// SPART 8N1 serial receiver driven by an oversample tick (enable).
// The start bit is validated at its midpoint. The data and stop bits are
// then sampled every OVERSAMPLE ticks. A correctly framed byte is loaded into
// rx_data and raises rda. A host read of address 2'b00 clears rda.
// Optional feature: define SPART_RX_SYNC_EN to place a 2-flop synchronizer
// on rxd. This adds two cycles of sampling latency.
module spart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      enable,
   input  logic      rxd,
   spart_rx_if.slave bus
);

   localparam int            CW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] TICK_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state_q,    state_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q,  bit_cnt_d;
   logic [7:0]    shift_q,    shift_d;
   logic [7:0]    rx_data_q,  rx_data_d;
   logic          rda_q,      rda_d;

   logic          rxd_smp_s;
   logic          load_s;
   logic          rd_clr_s;

`ifdef SPART_RX_SYNC_EN
   logic [1:0]    sync_q, sync_d;

   // Shift the raw line through two stages; stage 1 feeds the sampler.
   always_comb begin
      sync_d = {sync_q[0], rxd};
   end

   // Synchronizer flops reset to the idle-high line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rxd_smp_s = sync_q[1];
`else
   assign rxd_smp_s = rxd;
`endif

   // Frame FSM: counters and state move only on oversample ticks.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      load_s     = 1'b0;
      if (enable) begin
         case (state_q)
            IDLE: begin
               if (!rxd_smp_s) begin
                  state_d    = START;
                  tick_cnt_d = '0;
               end else begin
                  state_d    = IDLE;
               end
            end
            START: begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = '0;
                  if (!rxd_smp_s) begin
                     state_d   = DATA;
                     bit_cnt_d = 3'd0;
                  end else begin
                     // Line went back high before mid-bit: a glitch, not a start.
                     state_d   = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  shift_d    = {rxd_smp_s, shift_q[7:1]};
                  if (bit_cnt_q == 3'd7) begin
                     state_d   = STOP;
                     bit_cnt_d = 3'd0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (tick_cnt_q == TICK_LAST) begin
                  // Back to IDLE at the stop midpoint so the next start is seen on the next tick.
                  state_d    = IDLE;
                  tick_cnt_d = '0;
                  load_s     = rxd_smp_s;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d    = IDLE;
               tick_cnt_d = '0;
               bit_cnt_d  = 3'd0;
            end
         endcase
      end else begin
         state_d    = state_q;
         tick_cnt_d = tick_cnt_q;
      end
   end

   // Host-visible buffer: a valid stop loads the byte and wins over a same-cycle read-clear.
   always_comb begin
      rd_clr_s  = bus.iocs & bus.iorw & (bus.ioaddr == 2'b00);
      rda_d     = rda_q;
      rx_data_d = rx_data_q;
      if (load_s) begin
         rda_d     = 1'b1;
         rx_data_d = shift_q;
      end else if (rd_clr_s) begin
         rda_d     = 1'b0;
      end else begin
         rda_d     = rda_q;
      end
   end

   // State and output registers; reset dominates every other update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         rx_data_q  <= 8'h00;
         rda_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rda_q      <= rda_d;
      end
   end

   assign bus.rx_data = rx_data_q;
   assign bus.rda     = rda_q;

endmodule

// File: tb/tb_spart_rx.sv
// Testbench for spart_rx (OVERSAMPLE=16). It works with or without
// SPART_RX_SYNC_EN; the expected sampling latency follows that macro.
// It applies a table of whole frames, some hand-written corner sequences,
// and randomized line/tick/bus traffic checked every cycle against a
// tick-ordinal frame model.
module tb_spart_rx;

   localparam int OS  = 16;
   localparam int N   = 6000;
   localparam int GAP = 24;
`ifdef SPART_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk;
   logic rst;
   logic enable;
   logic rxd;

   spart_rx_if bus ();

   spart_rx #(.OVERSAMPLE(OS)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .rxd    (rxd),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] b;
      logic       stop;
      logic       rd_stop;
      logic       rd_after;
      logic       exp_pre;
      logic       exp_rda;
      logic [7:0] exp_dat;
   } vec_t;

   vec_t       tbl [6];
   logic       en_a   [N];
   logic       rxd_a  [N];
   logic       seen_a [N];
   logic [1:0] acc_a  [N];
   logic       exp_rda_a [N+1];
   logic [7:0] exp_dat_a [N+1];
   bit         stream [$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge (start of the next cycle).
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic frame_lvl(input logic [7:0] b, input logic stop, input int i);
      int idx;
      idx = i / OS;
      if (idx == 0) return 1'b0;
      else if (idx <= 8) return b[3'(idx - 1)];
      else if (idx == 9) return stop;
      else return 1'b1;
   endfunction

   // One frame with enable every cycle, followed by an idle gap.
   // Stop midpoint is sampled in cycle LAT+152; rda should move in cycle LAT+153.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_stop,
                             output logic pre, output logic post, output logic [7:0] post_dat);
      pre = 1'bx; post = 1'bx; post_dat = 8'hxx;
      for (int i = 0; i < 10 * OS + GAP; i++) begin
         rxd        = frame_lvl(b, stop, i);
         bus.iocs   = rd_stop && (i == LAT + 152);
         bus.iorw   = 1'b1;
         bus.ioaddr = 2'b00;
         cyc();
         if (i == LAT + 151) pre = bus.rda;
         if (i == LAT + 152) begin
            post     = bus.rda;
            post_dat = bus.rx_data;
         end
      end
      bus.iocs = 1'b0;
   endtask

   task automatic push_frame(input logic [7:0] b, input logic stop);
      repeat (OS) stream.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (OS) stream.push_back(b[i]);
      repeat (OS) stream.push_back(stop);
   endtask

   task automatic run_random(input int mode);
      int cnt, ord, t0, rel, k;
      bit busy;
      logic r, ld;
      logic [7:0] d, sh;
      // Tick pattern and host accesses.
      for (int c = 0; c < N; c++) begin
         case (mode)
            0:       en_a[c] = 1'b1;
            1:       en_a[c] = ($urandom_range(0, 1) == 0);
            2:       en_a[c] = ((c % 4) == 3);
            default: en_a[c] = !((c >= 100 && c < 180) || (c >= 400 && c < 450));
         endcase
         if ($urandom_range(0, 39) == 0) acc_a[c] = 2'd1;
         else if ($urandom_range(0, 39) == 0) acc_a[c] = 2'($urandom_range(2, 3));
         else acc_a[c] = 2'd0;
      end
      // Line contents in units of ticks: gaps, glitches, good and bad frames.
      stream.delete();
      if (mode == 3) begin
         repeat (10) stream.push_back(1'b1);
         push_frame(8'hB4, 1'b1);
      end
      while (stream.size() < N) begin
         repeat ($urandom_range(1, 30)) stream.push_back(1'b1);
         if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, OS / 2 - 2)) stream.push_back(1'b0);
         else push_frame(8'($urandom), ($urandom_range(0, 3) != 0));
      end
      cnt = 0;
      for (int c = 0; c < N; c++) begin
         rxd_a[c] = (cnt < stream.size()) ? stream[cnt] : 1'b1;
         if (en_a[c]) cnt++;
      end
      for (int c = 0; c < N; c++) seen_a[c] = (c >= LAT) ? rxd_a[c - LAT] : 1'b1;
      // Reference: samples fall at tick offsets OS/2 + k*OS after the start-detect tick.
      r = 1'b0; d = 8'h00; sh = 8'h00; ord = 0; busy = 1'b0; t0 = 0;
      for (int c = 0; c < N; c++) begin
         exp_rda_a[c] = r;
         exp_dat_a[c] = d;
         ld = 1'b0;
         if (en_a[c]) begin
            if (!busy) begin
               if (seen_a[c] == 1'b0) begin busy = 1'b1; t0 = ord; end
            end else begin
               rel = ord - t0;
               if (rel == OS / 2) begin
                  if (seen_a[c]) busy = 1'b0;
               end else if (rel > OS / 2 && ((rel - OS / 2) % OS) == 0) begin
                  k = (rel - OS / 2) / OS;
                  if (k <= 8) sh[3'(k - 1)] = seen_a[c];
                  else begin busy = 1'b0; ld = seen_a[c]; end
               end
            end
            ord++;
         end
         if (ld) begin r = 1'b1; d = sh; end
         else if (acc_a[c] == 2'd1) r = 1'b0;
      end
      exp_rda_a[N] = r;
      exp_dat_a[N] = d;
      // Apply to the DUT from a fresh reset.
      rst = 1'b1; enable = 1'b0; rxd = 1'b1; bus.iocs = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      for (int c = 0; c < N; c++) begin
         chk($sformatf("rand_rda m%0d c%0d", mode, c), bus.rda, exp_rda_a[c]);
         chk($sformatf("rand_dat m%0d c%0d", mode, c), bus.rx_data, exp_dat_a[c]);
         enable = en_a[c];
         rxd    = rxd_a[c];
         case (acc_a[c])
            2'd1:    begin bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00; end
            2'd2:    begin bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b00; end
            2'd3:    begin bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'($urandom_range(1, 3)); end
            default: begin bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00; end
         endcase
         cyc();
      end
      chk($sformatf("rand_rda m%0d end", mode), bus.rda, exp_rda_a[N]);
      chk($sformatf("rand_dat m%0d end", mode), bus.rx_data, exp_dat_a[N]);
      bus.iocs = 1'b0;
      enable   = 1'b1;
      rxd      = 1'b1;
   endtask

   initial begin
      logic pre, post;
      logic [7:0] pdat;

      tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
      tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
      tbl[2] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
      tbl[3] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3};
      tbl[4] = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3};
      tbl[5] = '{8'h69, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h69};

      rst = 1'b1; enable = 1'b1; rxd = 1'b1;
      bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
      cyc(); cyc();
      rst = 1'b0;
      chk("reset_rda", bus.rda, 1'b0);
      chk("reset_dat", bus.rx_data, 8'h00);
      repeat (4) cyc();

      // Table of whole frames with enable on every cycle.
      for (int v = 0; v < 6; v++) begin
         send_frame(tbl[v].b, tbl[v].stop, tbl[v].rd_stop, pre, post, pdat);
         chk($sformatf("tbl%0d_rda_pre", v), pre, tbl[v].exp_pre);
         chk($sformatf("tbl%0d_rda", v), post, tbl[v].exp_rda);
         chk($sformatf("tbl%0d_dat", v), pdat, tbl[v].exp_dat);
         if (tbl[v].rd_after) begin
            bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b01; cyc();
            bus.iorw = 1'b0; bus.ioaddr = 2'b00; cyc();
            bus.iocs = 1'b0; bus.iorw = 1'b1; cyc();
            chk($sformatf("tbl%0d_other_access", v), bus.rda, 1'b1);
            bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00; cyc();
            bus.iocs = 1'b0;
            chk($sformatf("tbl%0d_rd_clear", v), bus.rda, 1'b0);
            chk($sformatf("tbl%0d_rd_hold_dat", v), bus.rx_data, tbl[v].exp_dat);
         end
      end

      // Short low glitch: false start, outputs untouched.
      rxd = 1'b0;
      repeat (4) cyc();
      rxd = 1'b1;
      repeat (30) cyc();
      chk("glitch_rda", bus.rda, 1'b1);
      chk("glitch_dat", bus.rx_data, 8'h69);

      // Reset in the middle of the data bits, then a clean frame.
      for (int i = 0; i < 60; i++) begin
         rxd = frame_lvl(8'h96, 1'b1, i);
         cyc();
      end
      rst = 1'b1; rxd = 1'b1;
      cyc();
      rst = 1'b0;
      chk("middata_rst_rda", bus.rda, 1'b0);
      chk("middata_rst_dat", bus.rx_data, 8'h00);
      repeat (20) cyc();
      send_frame(8'h3C, 1'b1, 1'b0, pre, post, pdat);
      chk("after_rst_rda_pre", pre, 1'b0);
      chk("after_rst_rda", post, 1'b1);
      chk("after_rst_dat", pdat, 8'h3C);

      // Randomized traffic: full-rate, random, sparse and stalled ticks.
      for (int m = 0; m < 4; m++) run_random(m);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, enable ticks per bit period; even, 4..256.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: enable  input  1  oversample tick from the baud rate generator; one-cycle pulse.
REQ-005 Port: rxd  input  1  serial receive line; idle high.
REQ-006 Port: iocs  input  1  I/O chip select.
REQ-007 Port: iorw  input  1  1 = read, 0 = write.
REQ-008 Port: ioaddr  input  2  register address; 2'b00 = receive buffer.
REQ-009 Port: rx_data  output  8  last correctly framed byte received.
REQ-010 Port: rda  output  1  receive data available flag.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-012 State machine SHALL have states IDLE, START, DATA, STOP; counters and state SHALL advance only on cycles with enable=1.
REQ-013 IDLE: on a tick with sampled rxd=0, go to START with tick counter cleared; otherwise stay.
REQ-014 START: on the tick where tick counter reaches OVERSAMPLE/2-1, sample rxd; 0 -> DATA with tick counter and bit counter cleared; 1 -> IDLE (false start, no output change).
REQ-015 DATA: every OVERSAMPLE ticks sample rxd and shift it into bit 7 of an 8-bit shift register (shifting right); after the 8th sample go to STOP.
REQ-016 STOP: after OVERSAMPLE ticks sample rxd; 1 -> load shift register into rx_data and set rda; 0 -> framing error, discard byte, rx_data and rda unchanged; both cases go to IDLE.
REQ-017 rda SHALL assert on the clock edge following the edge on which a valid stop bit is sampled.
REQ-018 rda SHALL clear on the edge following a cycle with iocs=1, iorw=1, ioaddr=2'b00; any other access SHALL leave rda unchanged.
REQ-019 Simultaneous read-clear and valid stop in the same cycle: set wins, rda=1, rx_data = new byte.
REQ-020 Overrun: a new valid byte while rda=1 SHALL overwrite rx_data; rda stays 1.
REQ-021 rx_data SHALL be held stable between valid frames, independent of reads.
REQ-022 A new start bit SHALL be accepted from the first tick after returning to IDLE (stop-bit midpoint).
REQ-023 Tick counter width SHALL be ceil(log2(OVERSAMPLE)) bits; bit counter 3 bits; no wrap beyond defined terminal counts.

Reset
REQ-024 With rst=1 on a rising edge: state=IDLE, counters=0, shift register=0, rx_data=8'h00, rda=0, regardless of enable or frame in progress.
REQ-025 rst SHALL take priority over enable, read-clear and stop-bit load.

Configuration
REQ-026 Macro SPART_RX_SYNC_EN defined: rxd SHALL pass through a 2-flop synchronizer (reset to 1) before all sampling; sampling latency +2 cycles.
REQ-027 Macro SPART_RX_SYNC_EN undefined: rxd SHALL be sampled directly with no added latency; all other behaviour identical.

Verification
REQ-028 OVERSAMPLE=16, enable=1 every cycle, 16-cycle bits, frame 0xA5 -> rda=1, rx_data=8'hA5 one cycle after stop midpoint.
REQ-029 rxd low for 4 cycles then high, enable=1 -> state returns to IDLE, rda=0, rx_data unchanged.
REQ-030 After 0xA5 received, frame 0x3C with stop bit 0 -> rda stays at prior value, rx_data remains 8'hA5.
REQ-031 rda=1, read (iocs=1, iorw=1, ioaddr=00) -> rda=0 next cycle; read in the same cycle as valid stop of 0x5A -> rda=1, rx_data=8'h5A.
REQ-032 rst pulsed mid-DATA -> rx_data=8'h00, rda=0, state IDLE; following frame 0x3C received correctly.
REQ-033 enable held 0 during a frame -> no state or counter change; frame completes correctly once ticks resume; run with and without SPART_RX_SYNC_EN.
